// File: rtl/reed_solomon_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reed_solomon_encoder
// Brief    : Systematic RS(K+NPAR, K) encoder over GF(2^8). Message bytes
//            pass straight through; NPAR parity bytes from an LFSR division
//            by the generator polynomial follow, highest degree first.
// Revision : 1.0  initial release
// ============================================================================
module reed_solomon_encoder #(
    parameter int         K         = 239,
    parameter int         NPAR      = 16,
    parameter logic [8:0] PRIM_POLY = 9'h11D,
    parameter int         FCR       = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_parity,
    output logic        m_last,
    output logic        busy,
    output logic [31:0] cw_count
);

    typedef enum logic [0:0] {
        S_ENC_DATA   = 1'b0,
        S_ENC_PARITY = 1'b1
    } state_t;

    localparam logic [7:0] c_k_last = 8'(K - 1);
    localparam logic [5:0] c_p_last = 6'(NPAR - 1);

    // GF(2^8) multiply; with one constant operand it folds to an XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = sh[7] ? ((sh << 1) ^ PRIM_POLY[7:0]) : (sh << 1);
        end
        return acc;
    endfunction

    // Coefficient idx of g(x) = prod (x + alpha^(FCR+i)), evaluated at elaboration.
    function automatic logic [7:0] gen_coef(input int idx);
        logic [7:0] p [0:32];
        logic [7:0] root;
        for (int j = 0; j <= 32; j++) p[j] = 8'h00;
        p[0] = 8'h01;
        root = 8'h01;
        for (int j = 0; j < FCR; j++) root = gf_mul(root, 8'h02);
        for (int i = 0; i < NPAR; i++) begin
            for (int j = i + 1; j >= 1; j--) p[j] = p[j-1] ^ gf_mul(p[j], root);
            p[0] = gf_mul(p[0], root);
            root = gf_mul(root, 8'h02);
        end
        return p[idx];
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_lfsr [NPAR];
    logic [7:0]  r_count;
    logic [5:0]  r_pcount;
    logic        r_m_valid;
    logic [7:0]  r_m_data;
    logic        r_m_parity;
    logic        r_m_last;
    logic [31:0] r_cw_count;

    logic        w_out_free;
    logic        w_accept;
    logic        w_emit;
    logic        w_par_last;
    logic [7:0]  w_fb;
    logic [7:0]  w_fb_g [NPAR];

    assign w_out_free = !r_m_valid || m_ready;
    assign w_par_last = (r_pcount == c_p_last);
    assign w_fb       = s_data ^ r_lfsr[NPAR-1];

    for (genvar gi = 0; gi < NPAR; gi++) begin : g_tap
        localparam logic [7:0] c_g = gen_coef(gi);
        assign w_fb_g[gi] = gf_mul(w_fb, c_g);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_ENC_DATA;
        else          r_state <= w_state_next;
    end

    // Next-state decode and handshake qualification.
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        w_accept     = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            S_ENC_DATA: begin
                s_ready  = w_out_free;
                w_accept = s_valid && w_out_free;
                if (w_accept && (r_count == c_k_last)) w_state_next = S_ENC_PARITY;
            end
            S_ENC_PARITY: begin
                w_emit = w_out_free;
                if (w_emit && w_par_last) w_state_next = S_ENC_DATA;
            end
            default: w_state_next = S_ENC_DATA;
        endcase
    end

    // Datapath: LFSR update, byte counters and the single output register stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NPAR; i++) r_lfsr[i] <= 8'h00;
            r_count    <= 8'h00;
            r_pcount   <= 6'h00;
            r_m_valid  <= 1'b0;
            r_m_data   <= 8'h00;
            r_m_parity <= 1'b0;
            r_m_last   <= 1'b0;
            r_cw_count <= 32'h0;
        end else if (w_accept) begin
            r_m_data   <= s_data;
            r_m_valid  <= 1'b1;
            r_m_parity <= 1'b0;
            r_m_last   <= 1'b0;
            r_lfsr[0]  <= w_fb_g[0];
            for (int i = 1; i < NPAR; i++) r_lfsr[i] <= r_lfsr[i-1] ^ w_fb_g[i];
            r_count    <= (r_count == c_k_last) ? 8'h00 : (r_count + 8'd1);
        end else if (w_emit) begin
            r_m_data   <= r_lfsr[NPAR-1];
            r_m_valid  <= 1'b1;
            r_m_parity <= 1'b1;
            r_m_last   <= w_par_last;
            r_lfsr[0]  <= 8'h00;
            for (int i = 1; i < NPAR; i++) r_lfsr[i] <= r_lfsr[i-1];
            if (w_par_last) begin
                r_pcount   <= 6'h00;
                r_cw_count <= r_cw_count + 32'd1;
            end else begin
                r_pcount   <= r_pcount + 6'd1;
            end
        end else if (m_ready) begin
            r_m_valid  <= 1'b0;
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_parity = r_m_parity;
    assign m_last   = r_m_last;
    assign cw_count = r_cw_count;
    // A held final byte still belongs to the codeword until it is taken.
    assign busy     = (r_count != 8'h00) || (r_state == S_ENC_PARITY) || (r_m_valid && r_m_last);

endmodule
`default_nettype wire

// File: tb/tb_reed_solomon_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reed_solomon_encoder
// Brief    : Directed self-checking bench for reed_solomon_encoder (default
//            RS(255,239) instance plus a K=4/NPAR=2 instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_reed_solomon_encoder;

    localparam int K    = 239;
    localparam int NPAR = 16;
    localparam int N    = K + NPAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        s_valid, s_ready, m_valid, m_ready, m_parity, m_last, busy;
    logic [7:0]  s_data, m_data;
    logic [31:0] cw_count;

    logic        s2_valid, s2_ready, m2_valid, m2_ready, m2_parity, m2_last, busy2;
    logic [7:0]  s2_data, m2_data;
    logic [31:0] cw_count2;

    reed_solomon_encoder u_dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_parity(m_parity), .m_last(m_last), .busy(busy), .cw_count(cw_count)
    );

    reed_solomon_encoder #(.K(4), .NPAR(2)) u_dut_small (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data),
        .m_parity(m2_parity), .m_last(m2_last), .busy(busy2), .cw_count(cw_count2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] q_data [$];
    logic       q_par  [$];
    logic       q_last [$];
    int         q_cyc  [$];
    logic [9:0] q2     [$];
    logic [7:0] msg    [K];
    logic [7:0] ref_cw [N];

    // {last, parity, data} for message 01 02 03 04 with g(x)=x^2+3x+2.
    logic [9:0] exp2 [6] = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h104, 10'h300};

    logic       bp_mode = 1'b0;
    logic [6:0] bp_lf   = 7'h5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = 8'h00;
        logic [7:0] sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc ^= sh;
            sh = sh[7] ? ((sh << 1) ^ 8'h1D) : (sh << 1);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gpow(input int e);
        logic [7:0] r = 8'h01;
        for (int k = 0; k < e; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_par.push_back(m_parity);
            q_last.push_back(m_last);
            q_cyc.push_back(cyc);
        end
        if (reset_n && m2_valid && m2_ready) q2.push_back({m2_last, m2_parity, m2_data});
    end

    // Downstream ready: always high, or a 7-bit LFSR pattern when throttling.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = bp_mode ? bp_lf[0] : 1'b1;
            bp_lf   = {bp_lf[5:0], bp_lf[6] ^ bp_lf[5]};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_par.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic fill_msg(input int k);
        for (int i = 0; i < K; i++) msg[i] = 8'((i * (k + 3) + k * 17 + 5) & 255);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        bit done = 1'b0;
        repeat (gap) begin s_valid = 1'b0; @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_msg(input bit gaps);
        for (int i = 0; i < K; i++) send_byte(msg[i], (gaps && (i % 5 == 2)) ? 2 : 0);
        s_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input string tag);
        int t = 0;
        while (q_data.size() < n && t < 20000) begin @(negedge clk); t++; end
        if (q_data.size() < n) check({tag, "_timeout"}, q_data.size(), n);
    endtask

    task automatic verify_cw(input int base, input string tag);
        int bad_d = 0;
        int bad_f = 0;
        logic [7:0] s, a;
        logic [7:0] synor = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (i < K && q_data[base+i] !== msg[i]) bad_d++;
            if (q_par[base+i]  !== (i >= K))     bad_f++;
            if (q_last[base+i] !== (i == N - 1)) bad_f++;
        end
        for (int j = 0; j < NPAR; j++) begin
            a = gpow(j);
            s = 8'h00;
            for (int i = 0; i < N; i++) s = gmul(s, a) ^ q_data[base+i];
            synor |= s;
        end
        check({tag, "_data"},     bad_d, 0);
        check({tag, "_flags"},    bad_f, 0);
        check({tag, "_syndrome"}, synor, 0);
    endtask

    initial begin
        int nz;
        int t;
        logic [7:0] g15;

        reset_n = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        s2_valid = 1'b0; s2_data = 8'h00; m2_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cw_count", cw_count, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_data", m_data, 0);
        sync();

        // Small build: message 01 02 03 04 -> parity 04 00.
        for (int i = 0; i < 4; i++) begin
            s2_valid = 1'b1;
            s2_data  = 8'(i + 1);
            sync();
        end
        s2_valid = 1'b0;
        t = 0;
        while (q2.size() < 6 && t < 100) begin @(negedge clk); t++; end
        for (int i = 0; i < 6; i++) check("small_byte", q2[i], exp2[i]);
        check("small_cw_count", cw_count2, 1);
        sync();

        // All-zero message.
        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        clear_q();
        send_msg(1'b0);
        wait_q(N, "zero");
        verify_cw(0, "zero");
        nz = 0;
        for (int i = 0; i < N; i++) if (q_data[i] != 8'h00) nz++;
        check("zero_all_bytes", nz, 0);
        check("zero_cw_count", cw_count, 1);
        @(negedge clk);
        check("zero_busy_after", busy, 0);
        sync();

        // Single 0x01 in the last message byte: parity is g(x) itself.
        msg[K-1] = 8'h01;
        clear_q();
        send_msg(1'b0);
        wait_q(N, "unit");
        verify_cw(0, "unit");
        g15 = 8'h00;
        for (int j = 0; j < NPAR; j++) g15 ^= gpow(j);
        check("unit_g15", q_data[K], g15);
        check("unit_g0", q_data[N-1], gpow(120));
        check("unit_cw_count", cw_count, 2);
        sync();

        // Patterned message, free-flowing then throttled with source gaps.
        for (int i = 0; i < K; i++) msg[i] = 8'((i * 37 + 11) & 255);
        clear_q();
        send_msg(1'b0);
        wait_q(N, "pat");
        verify_cw(0, "pat");
        for (int i = 0; i < N; i++) ref_cw[i] = q_data[i];
        sync();
        clear_q();
        bp_mode = 1'b1;
        send_msg(1'b1);
        wait_q(N, "bp");
        bp_mode = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_count", q_data.size(), N);
        nz = 0;
        for (int i = 0; i < N; i++) if (q_data[i] !== ref_cw[i]) nz++;
        check("bp_same_as_free", nz, 0);
        verify_cw(0, "bp");
        check("bp_cw_count", cw_count, 4);
        sync();

        // Four back-to-back codewords with no idle cycles.
        clear_q();
        for (int k = 0; k < 4; k++) begin
            fill_msg(k);
            send_msg(1'b0);
        end
        wait_q(4 * N, "b2b");
        for (int k = 0; k < 4; k++) begin
            fill_msg(k);
            verify_cw(k * N, "b2b");
        end
        check("b2b_span", q_cyc[4*N-1] - q_cyc[0], 4 * N - 1);
        check("b2b_cw_count", cw_count, 8);
        sync();

        // Reset in the middle of a codeword, then a clean zero message.
        fill_msg(7);
        for (int i = 0; i < 100; i++) send_byte(msg[i], 0);
        s_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cw_count", cw_count, 0);
        sync();
        clear_q();
        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        send_msg(1'b0);
        wait_q(N, "post_rst");
        verify_cw(0, "post_rst");
        nz = 0;
        for (int i = 0; i < N; i++) if (q_data[i] != 8'h00) nz++;
        check("post_rst_all_zero", nz, 0);
        check("post_rst_cw_count", cw_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
